// File: rtl/sprite_scheduler.sv
// Frame-level sprite scheduler: each frame tick it erases/draws client 0 then client 1 and muxes the active client's pixels onto the VGA plot port.
// Latency: the first request pulse comes one cycle after the tick. Erase windows last ERASE_CYCLES. Draw waits last until finish or DRAW_TIMEOUT.
// Backpressure: clients stall the walk by holding finish low, bounded by DRAW_TIMEOUT. A tick that lands while a frame is active is dropped and flagged.
//
// Ports:
//   clk, reset (async, active-low), enable (act on frame ticks)
//   draw_0/1, erase_0/1 : one-cycle requests; finish_0/1 : client draw-complete level
//   x_0/1, y_0/1, colour_0/1 : client pixel streams
//   vga_x/vga_y/vga_colour/plot : muxed pixel port
//   busy, frame_done, overrun (sticky), timeout_err (sticky) : status
module sprite_scheduler #(
    parameter int FRAME_CYCLES = 833333,
    parameter int ERASE_CYCLES = 44,
    parameter int DRAW_TIMEOUT = 63
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    output logic       draw_0,
    output logic       draw_1,
    output logic       erase_0,
    output logic       erase_1,
    input  logic       finish_0,
    input  logic       finish_1,
    input  logic [8:0] x_0,
    input  logic [8:0] x_1,
    input  logic [7:0] y_0,
    input  logic [7:0] y_1,
    input  logic [2:0] colour_0,
    input  logic [2:0] colour_1,
    output logic [8:0] vga_x,
    output logic [7:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       busy,
    output logic       frame_done,
    output logic       overrun,
    output logic       timeout_err
);

    localparam int CW   = $clog2(FRAME_CYCLES);
    localparam int WMAX = (ERASE_CYCLES > DRAW_TIMEOUT) ? ERASE_CYCLES : DRAW_TIMEOUT;
    localparam int WW   = (WMAX > 1) ? $clog2(WMAX) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERASE_REQ,
        S_ERASE_WAIT,
        S_DRAW_REQ,
        S_DRAW_WAIT,
        S_NEXT,
        S_DONE
    } state_t;

    state_t        state;
    logic          sel;
    logic [1:0]    drawn;
    logic [CW-1:0] frame_cnt;
    logic [WW-1:0] wait_cnt;
    logic [1:0]    draw_q;
    logic [1:0]    erase_q;
    logic          plot_q;
    logic          tick;
    logic          finish_sel;

    assign tick       = (frame_cnt == CW'(FRAME_CYCLES - 1));
    assign finish_sel = sel ? finish_1 : finish_0;

    assign draw_0  = draw_q[0];
    assign draw_1  = draw_q[1];
    assign erase_0 = erase_q[0];
    assign erase_1 = erase_q[1];

    // The client's completion cycle must not write a pixel, so finish gates the
    // registered plot enable combinationally while waiting on a draw.
    assign plot = plot_q & ~((state == S_DRAW_WAIT) & finish_sel);

    assign vga_x      = sel ? x_1      : x_0;
    assign vga_y      = sel ? y_1      : y_0;
    assign vga_colour = sel ? colour_1 : colour_0;

    // Free-running frame timebase, independent of enable.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            frame_cnt <= '0;
        end else if (tick) begin
            frame_cnt <= '0;
        end else begin
            frame_cnt <= frame_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            sel         <= 1'b0;
            drawn       <= 2'b00;
            wait_cnt    <= '0;
            draw_q      <= 2'b00;
            erase_q     <= 2'b00;
            plot_q      <= 1'b0;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            overrun     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            draw_q     <= 2'b00;
            erase_q    <= 2'b00;
            frame_done <= 1'b0;

            // Ticks while disabled are ignored entirely. DONE still counts as
            // busy, so a tick landing there is dropped as an overrun.
            if (tick && enable && (state != S_IDLE)) begin
                overrun <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (tick && enable) begin
                        sel  <= 1'b0;
                        busy <= 1'b1;
                        if (drawn[0]) begin
                            state   <= S_ERASE_REQ;
                            erase_q <= 2'b01;
                        end else begin
                            state  <= S_DRAW_REQ;
                            draw_q <= 2'b01;
                        end
                    end
                end

                S_ERASE_REQ: begin
                    state    <= S_ERASE_WAIT;
                    wait_cnt <= '0;
                    plot_q   <= 1'b1;
                end

                S_ERASE_WAIT: begin
                    if (wait_cnt == WW'(ERASE_CYCLES - 1)) begin
                        state  <= S_DRAW_REQ;
                        plot_q <= 1'b0;
                        draw_q <= {sel, ~sel};
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_DRAW_REQ: begin
                    // finish is deliberately not looked at here.
                    state    <= S_DRAW_WAIT;
                    wait_cnt <= '0;
                    plot_q   <= 1'b1;
                end

                S_DRAW_WAIT: begin
                    if (finish_sel) begin
                        state  <= S_NEXT;
                        plot_q <= 1'b0;
                    end else if (wait_cnt == WW'(DRAW_TIMEOUT - 1)) begin
                        state       <= S_NEXT;
                        plot_q      <= 1'b0;
                        timeout_err <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end

                S_NEXT: begin
                    drawn[sel] <= 1'b1;
                    if (!sel) begin
                        sel <= 1'b1;
                        if (drawn[1]) begin
                            state   <= S_ERASE_REQ;
                            erase_q <= 2'b10;
                        end else begin
                            state  <= S_DRAW_REQ;
                            draw_q <= 2'b10;
                        end
                    end else begin
                        state      <= S_DONE;
                        frame_done <= 1'b1;
                        busy       <= 1'b0;
                    end
                end

                S_DONE: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sprite_scheduler.sv
// Directed bench for sprite_scheduler. The main instance uses a 256-cycle frame.
// A second instance has a long draw timeout and finish tied low, so its frames outlast the tick period.
module tb_sprite_scheduler;

    logic       clk;
    logic       reset;
    logic       enable;
    logic       finish_0, finish_1;
    logic [8:0] x_0, x_1;
    logic [7:0] y_0, y_1;
    logic [2:0] colour_0, colour_1;

    logic       draw_0, draw_1, erase_0, erase_1;
    logic [8:0] vga_x;
    logic [7:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot, busy, frame_done, overrun, timeout_err;

    logic       zero_f;
    logic       o_draw_0, o_draw_1, o_erase_0, o_erase_1;
    logic [8:0] o_vga_x;
    logic [7:0] o_vga_y;
    logic [2:0] o_vga_colour;
    logic       o_plot, o_busy, o_frame_done, o_overrun, o_timeout_err;

    int compared = 0;
    int mismatched = 0;
    int viol = 0;
    int ovr_pulses = 0;

    sprite_scheduler #(.FRAME_CYCLES(256), .ERASE_CYCLES(44), .DRAW_TIMEOUT(63)) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .draw_0(draw_0), .draw_1(draw_1), .erase_0(erase_0), .erase_1(erase_1),
        .finish_0(finish_0), .finish_1(finish_1),
        .x_0(x_0), .x_1(x_1), .y_0(y_0), .y_1(y_1),
        .colour_0(colour_0), .colour_1(colour_1),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .plot(plot), .busy(busy), .frame_done(frame_done),
        .overrun(overrun), .timeout_err(timeout_err)
    );

    sprite_scheduler #(.FRAME_CYCLES(256), .ERASE_CYCLES(44), .DRAW_TIMEOUT(200)) dut_ovr (
        .clk(clk), .reset(reset), .enable(enable),
        .draw_0(o_draw_0), .draw_1(o_draw_1), .erase_0(o_erase_0), .erase_1(o_erase_1),
        .finish_0(zero_f), .finish_1(zero_f),
        .x_0(x_0), .x_1(x_1), .y_0(y_0), .y_1(y_1),
        .colour_0(colour_0), .colour_1(colour_1),
        .vga_x(o_vga_x), .vga_y(o_vga_y), .vga_colour(o_vga_colour),
        .plot(o_plot), .busy(o_busy), .frame_done(o_frame_done),
        .overrun(o_overrun), .timeout_err(o_timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol monitors: no draw with erase, never both clients at once; count overrun-instance requests.
    always @(posedge clk) begin
        if ((draw_0 | draw_1) && (erase_0 | erase_1)) viol = viol + 1;
        if ((draw_0 | erase_0) && (draw_1 | erase_1)) viol = viol + 1;
        if (o_draw_0 | o_draw_1 | o_erase_0 | o_erase_1) ovr_pulses = ovr_pulses + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic cond(input int s);
        case (s)
            0:       return draw_0;
            1:       return erase_0;
            2:       return draw_1;
            3:       return erase_1;
            4:       return draw_0 | erase_0;
            5:       return timeout_err;
            default: return 1'b0;
        endcase
    endfunction

    // Step until cond(s) holds or limit expires; count plot cycles and pixel mismatches against client c.
    task automatic wait_for(input int s, input int limit, input int c,
                            output int n, output int np, output int nbad);
        logic [19:0] want;
        n = 0; np = 0; nbad = 0;
        do begin
            step();
            n++;
            want = c ? {x_1, y_1, colour_1} : {x_0, y_0, colour_0};
            if (plot) begin
                np++;
                if ({vga_x, vga_y, vga_colour} !== want) nbad++;
            end
        end while (!cond(s) && n < limit);
    endtask

    initial begin
        int n, np, nbad, act;
        reset = 1'b1; enable = 1'b1; finish_0 = 1'b0; finish_1 = 1'b0; zero_f = 1'b0;
        x_0 = 9'd300; y_0 = 8'd200; colour_0 = 3'd5;
        x_1 = 9'd17;  y_1 = 8'd99;  colour_1 = 3'd2;
        #1 reset = 1'b0;
        #1;
        check("reset_outputs", {draw_0, draw_1, erase_0, erase_1, plot, busy, frame_done, overrun, timeout_err}, 9'd0);
        #10 reset = 1'b1;

        // Frame 1: no erase, draw_0 first, one cycle after the tick.
        wait_for(4, 400, 0, n, np, nbad);
        check("f1_first_req_latency", n, 256);
        check("f1_draw0_no_erase", {draw_0, erase_0, erase_1, draw_1, busy, plot}, 6'b100010);
        step();
        check("f1_draw0_one_cycle", {draw_0, plot}, 2'b01);
        check("f1_vga_client0", {vga_x, vga_y, vga_colour}, {x_0, y_0, colour_0});
        repeat (42) step();
        finish_0 = 1'b1;
        #1;
        check("f1_plot_low_on_finish", plot, 1'b0);
        step();
        finish_0 = 1'b0;
        check("f1_next_state", {draw_1, plot, busy}, 3'b001);
        step();
        check("f1_draw1", {draw_1, erase_1, draw_0}, 3'b100);
        finish_1 = 1'b1;   // high during the draw request: must be ignored
        step();
        check("f1_finish_ignored_in_req", {frame_done, busy, plot}, 3'b010);
        step();
        check("f1_next_no_done", frame_done, 1'b0);
        step();
        finish_1 = 1'b0;
        check("f1_frame_done", {frame_done, busy, timeout_err, overrun}, 4'b1000);
        step();
        check("f1_done_one_cycle", frame_done, 1'b0);
        check("ovr_no_overrun_yet", o_overrun, 1'b0);

        // Frame 2: erase windows for both clients, then a draw timeout on client 1.
        wait_for(1, 300, 0, n, np, nbad);
        check("f2_erase0_latency", n, 207);
        check("f2_erase0_only", {erase_0, draw_0, busy}, 3'b101);
        check("ovr_overrun_set", {o_overrun, o_busy, o_draw_0, o_erase_0}, 4'b1100);
        wait_for(0, 60, 0, n, np, nbad);
        check("f2_erase0_window_len", n, 45);
        check("f2_erase0_plot_cycles", np, 44);
        check("f2_erase0_vga", nbad, 0);
        step();
        finish_0 = 1'b1;
        step();
        finish_0 = 1'b0;
        step();
        check("f2_erase1", {erase_1, erase_0, draw_1}, 3'b100);
        wait_for(2, 60, 1, n, np, nbad);
        check("f2_erase1_window_len", n, 45);
        check("f2_erase1_plot_cycles", np, 44);
        check("f2_erase1_vga", nbad, 0);
        wait_for(5, 100, 1, n, np, nbad);
        check("f2_timeout_cycles", n, 64);
        check("f2_timeout_plot_cycles", np, 63);
        step();
        check("f2_done_after_timeout", {frame_done, busy, timeout_err}, 3'b101);
        step();

        // Frame 3 proceeds after the timeout; reset lands in client 1's erase window.
        wait_for(1, 200, 0, n, np, nbad);
        check("f3_erase0_latency", n, 97);
        check("ovr_frame2_starts", o_erase_0, 1'b1);
        check("ovr_request_count", ovr_pulses, 2);
        finish_0 = 1'b1;
        finish_1 = 1'b1;
        wait_for(3, 100, 0, n, np, nbad);
        check("f3_erase1_latency", n, 48);
        repeat (10) step();
        check("f3_in_erase1_window", {plot, vga_x}, {1'b1, x_1});
        reset = 1'b0;
        #1;
        check("async_reset_outputs", {draw_0, draw_1, erase_0, erase_1, plot, busy, frame_done, overrun, timeout_err}, 9'd0);
        step();
        step();
        reset = 1'b1;

        // After reset: no erase pulses, draw_0 then draw_1.
        wait_for(4, 400, 0, n, np, nbad);
        check("r_first_req_latency", n, 256);
        check("r_draw0_no_erase", {draw_0, erase_0}, 2'b10);
        step(); step(); step();
        check("r_draw1_no_erase", {draw_1, erase_1}, 2'b10);
        step(); step(); step();
        check("r_frame_done", {frame_done, busy}, 2'b10);
        step();

        // Three ticks while disabled: no activity, no overrun.
        enable = 1'b0;
        act = 0;
        for (int i = 0; i < 768; i++) begin
            step();
            if (draw_0 | draw_1 | erase_0 | erase_1 | plot | busy) act++;
        end
        check("dis_no_activity", act, 0);
        check("dis_no_overrun", overrun, 1'b0);
        enable = 1'b1;
        wait_for(4, 400, 0, n, np, nbad);
        check("en_resume_latency", n, 249);
        check("en_resume_erase0", {erase_0, draw_0, busy}, 3'b101);
        check("protocol_violations", viol, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/sprite_scheduler.md
# sprite_scheduler

Frame-level initiator for the sprite draw/erase handshake. Once per frame it walks a fixed set of two sprite clients (client 0 = player ship, client 1 = next sprite), pulses `erase_N` then `draw_N` to each, waits for completion, and muxes the selected client's pixel stream onto the single VGA adapter plot port. It sits between the sprite blocks and the VGA adapter and is the only driver of `plot`.

## Interface
- `FRAME_CYCLES`, 833333, clk cycles per frame tick (60 Hz at 50 MHz); must be ≥ 256
- `ERASE_CYCLES`, 44, fixed cycles the erase window stays open (sprites report no erase completion)
- `DRAW_TIMEOUT`, 63, max cycles to wait for `finish_N` after a draw pulse
- `clk` in 1 system clock
- `reset` in 1 asynchronous, active-low reset
- `enable` in 1 1 = frame ticks are acted on; 0 = ticks ignored, current frame completes
- `draw_0`, `draw_1` out 1 one-cycle draw request per client
- `erase_0`, `erase_1` out 1 one-cycle erase request per client
- `finish_0`, `finish_1` in 1 client draw-complete level
- `x_0`, `x_1` in 9 client pixel x
- `y_0`, `y_1` in 8 client pixel y
- `colour_0`, `colour_1` in 3 client pixel colour
- `vga_x` out 9, `vga_y` out 8, `vga_colour` out 3: muxed pixel of the selected client
- `plot` out 1 VGA write enable
- `busy` out 1 high from frame start to frame end
- `frame_done` out 1 one-cycle pulse when both clients are serviced
- `overrun` out 1 sticky: a tick arrived while busy
- `timeout_err` out 1 sticky: a draw exceeded `DRAW_TIMEOUT`

## Operation
- Frame counter: free-running 0..FRAME_CYCLES-1, wraps to 0; tick = counter at FRAME_CYCLES-1. Runs regardless of `enable`.
- Per-client `drawn` flag, cleared by reset, set when that client's draw completes or times out.
- States: IDLE, ERASE_REQ, ERASE_WAIT, DRAW_REQ, DRAW_WAIT, NEXT, DONE. Client index `sel` (0/1).
- IDLE: on tick with `enable`=1 → `sel`=0, busy=1; go ERASE_REQ if `drawn[sel]`, else DRAW_REQ.
- ERASE_REQ: `erase_sel`=1 for exactly this cycle; → ERASE_WAIT, window counter cleared.
- ERASE_WAIT: plot=1; counts ERASE_CYCLES cycles, then → DRAW_REQ.
- DRAW_REQ: `draw_sel`=1 for exactly this cycle (clean rising edge; clients update position on it); → DRAW_WAIT, wait counter cleared.
- DRAW_WAIT: plot=1 while `finish_sel`=0. On `finish_sel`=1 → NEXT (plot=0 that cycle). If wait count reaches DRAW_TIMEOUT first → set `timeout_err`, → NEXT.
- NEXT: set `drawn[sel]`; if `sel`=0 → `sel`=1, go ERASE_REQ/DRAW_REQ per `drawn[1]`; if `sel`=1 → DONE.
- DONE: `frame_done`=1 one cycle, busy=0; → IDLE.
- Mux: `vga_x/vga_y/vga_colour` = client `sel` inputs, combinational, valid whenever plot=1.
- Never assert `draw_N` and `erase_N` in the same cycle; never address both clients in one cycle.

## Timing
- Reset (async, any state): state=IDLE, sel=0, both `drawn`=0, frame counter=0, all request outputs, plot, busy, frame_done=0, overrun=0, timeout_err=0. Reset mid-draw abandons the frame without further pulses.
- Tick → request latency: first request pulse on the cycle after the tick cycle.
- First frame after reset: no erase pulses (drawn=0); draw_0, then draw_1.
- Erase window: plot high exactly ERASE_CYCLES cycles, starting cycle after `erase_N`.
- Tick while busy: frame not restarted, `overrun` set, tick dropped.
- Tick on the same cycle as DONE: treated as busy → overrun, dropped.
- `finish_sel` already high in DRAW_REQ cycle is ignored; only sampled in DRAW_WAIT.
- `enable` deasserted mid-frame: frame completes normally; following ticks ignored, no overrun.
- Sticky flags clear only on reset.

## Test plan
- Reset then FRAME_CYCLES=256, enable=1: first tick → draw_0 one cycle, no erase; finish_0 after 43 cycles → draw_1; finish_1 → frame_done one cycle, busy low.
- Second frame: erase_0 pulse, plot high 44 cycles with vga_* = x_0/y_0/colour_0, then draw_0; same for client 1; erase never coincides with draw.
- finish_1 held low: timeout_err set after 63 wait cycles, frame_done still pulses, next frame proceeds.
- Clients delaying finish beyond FRAME_CYCLES: overrun set on the tick during busy, no restart, no extra requests.
- Assert reset during ERASE_WAIT of client 1: all outputs 0 immediately (asynchronous), next frame draws both clients without erase.
- enable=0 for three ticks: no requests, no overrun; enable=1 → service resumes at next tick.
